// File: rtl/fanout_pkg.sv
// fanout_pkg: shared types and defaults for the eager-fork fanout controller
// Holds the fork state enum, default branch/payload widths and the default-width mask type.
package fanout_pkg;
   localparam int NUM_BRANCH_DEF = 7;
   localparam int DATA_WIDTH_DEF = 16;
   typedef enum logic {FORK_IDLE, FORK_PARTIAL} fork_state_e;
   typedef logic [NUM_BRANCH_DEF-1:0] branch_mask_t;
endpackage

// File: rtl/fanout_fork_ctrl_if.sv
// fanout_fork_ctrl_if: ready/valid bundle for one producer broadcasting to NUM_BRANCH consumers
// Upstream: in_valid/in_data/in_ready. Downstream: out_valid/out_data per branch, out_ready per branch.
// master = producer/consumer side driving stimulus, slave = the fork controller.
interface fanout_fork_ctrl_if import fanout_pkg::*; #(
   parameter int NUM_BRANCH = NUM_BRANCH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_ready;
   logic [NUM_BRANCH-1:0] out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic [NUM_BRANCH-1:0] out_ready;
   modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
   modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/fanout_ready_and.sv
// fanout_ready_and: upstream ready reduction over enabled, not-yet-taken branches
// Ports: mask_i branch enables, taken_i branches already served, ready_i branch readies, ready_o upstream ready.
module fanout_ready_and #(
   parameter int N = 7
) (
   input  logic [N-1:0] mask_i,
   input  logic [N-1:0] taken_i,
   input  logic [N-1:0] ready_i,
   output logic         ready_o
);
   assign ready_o = &(~mask_i | taken_i | ready_i);
endmodule

// File: rtl/fanout_fork_ctrl.sv
// fanout_fork_ctrl: eager fork that releases upstream only after every enabled branch has taken the token
// Ports: clk, rst_n (async active-low), flush (sync clear of in-flight state),
// cfg_wr/cfg_mask/cfg_err/mask_q (branch-enable config), bus (fork handshake bundle),
// busy (token partially delivered), tok_count (completed tokens, wrapping).
module fanout_fork_ctrl import fanout_pkg::*; #(
   parameter int                    NUM_BRANCH = NUM_BRANCH_DEF,
   parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
   parameter logic [NUM_BRANCH-1:0] RESET_MASK = '0,
   parameter int                    CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  cfg_wr,
   input  logic [NUM_BRANCH-1:0] cfg_mask,
   output logic                  cfg_err,
   output logic [NUM_BRANCH-1:0] mask_q,
   fanout_fork_ctrl_if.slave     bus,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  tok_count
);
   fork_state_e           state_q;
   logic [NUM_BRANCH-1:0] taken_q, taken_d, acc;
   logic [CNT_WIDTH-1:0]  tok_count_q;
   logic                  cfg_err_q, fire;
   fanout_ready_and #(.N(NUM_BRANCH)) u_ready_and (
      .mask_i  (mask_q),
      .taken_i (taken_q),
      .ready_i (bus.out_ready),
      .ready_o (bus.in_ready)
   );
   assign bus.out_valid = {NUM_BRANCH{bus.in_valid}} & mask_q & ~taken_q;
   assign bus.out_data  = DATA_WIDTH'(bus.in_data);
   assign acc           = bus.out_valid & bus.out_ready;
   assign fire          = bus.in_valid & bus.in_ready;
   // Accumulate acceptances; a completing token clears everything instead.
   assign taken_d       = fire ? '0 : taken_q | acc;
   assign busy          = state_q == FORK_PARTIAL;
   assign tok_count     = tok_count_q;
   assign cfg_err       = cfg_err_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FORK_IDLE;
         taken_q     <= '0;
         mask_q      <= RESET_MASK;
         tok_count_q <= '0;
         cfg_err_q   <= 1'b0;
      end else begin
         cfg_err_q <= 1'b0;
         if (flush) begin
            state_q <= FORK_IDLE;
            taken_q <= '0;
         end else begin
            taken_q     <= taken_d;
            state_q     <= |taken_d ? FORK_PARTIAL : FORK_IDLE;
            tok_count_q <= tok_count_q + CNT_WIDTH'(fire);
            // Mask may only change between tokens so taken bits never refer to a stale mask.
            if (cfg_wr) begin
               if (state_q == FORK_IDLE && !(|acc)) mask_q <= cfg_mask;
               else cfg_err_q <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// tb_fanout_fork_ctrl: directed-vector scoreboard bench for the eager-fork fanout controller
module tb_fanout_fork_ctrl;
   import fanout_pkg::*;
   localparam int CW = 4;
   typedef struct {
      string         name;
      logic [15:0]   d;
      branch_mask_t  ov;
      logic          ir;
      logic          busy;
      logic [CW-1:0] cnt;
      branch_mask_t  mask;
      logic          err;
   } exp_t;
   exp_t q[$];
   logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0, cfg_wr = 1'b0;
   logic          cfg_err, busy;
   branch_mask_t  cfg_mask = '0, mask_q;
   logic [CW-1:0] tok_count;
   int            checks = 0, errors = 0;
   fanout_fork_ctrl_if #(.NUM_BRANCH(7), .DATA_WIDTH(16)) bus ();
   fanout_fork_ctrl #(.NUM_BRANCH(7), .DATA_WIDTH(16), .RESET_MASK(7'h07), .CNT_WIDTH(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .cfg_wr    (cfg_wr),
      .cfg_mask  (cfg_mask),
      .cfg_err   (cfg_err),
      .mask_q    (mask_q),
      .bus       (bus),
      .busy      (busy),
      .tok_count (tok_count)
   );
   always #5 clk = ~clk;
   task automatic chk(input string n, input string f, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s %s got %0h want %0h", n, f, a, e);
      end
   endtask
   // Apply one cycle of stimulus just after the edge and queue what the DUT must show that cycle.
   task automatic v(input string n, input logic r, input logic iv, input logic [15:0] d,
                    input branch_mask_t ordy, input logic fl, input logic wr, input branch_mask_t cm,
                    input branch_mask_t ov, input logic ir, input logic b, input logic [CW-1:0] cnt,
                    input branch_mask_t m, input logic e);
      @(posedge clk);
      #1;
      rst_n = r;
      bus.in_valid = iv;
      bus.in_data = d;
      bus.out_ready = ordy;
      flush = fl;
      cfg_wr = wr;
      cfg_mask = cm;
      q.push_back('{name: n, d: d, ov: ov, ir: ir, busy: b, cnt: cnt, mask: m, err: e});
   endtask
   always @(negedge clk) begin
      exp_t x;
      if (q.size() > 0) begin
         x = q.pop_front();
         chk(x.name, "out_valid", 32'(bus.out_valid), 32'(x.ov));
         chk(x.name, "in_ready", 32'(bus.in_ready), 32'(x.ir));
         chk(x.name, "out_data", 32'(bus.out_data), 32'(x.d));
         chk(x.name, "busy", 32'(busy), 32'(x.busy));
         chk(x.name, "tok_count", 32'(tok_count), 32'(x.cnt));
         chk(x.name, "mask_q", 32'(mask_q), 32'(x.mask));
         chk(x.name, "cfg_err", 32'(cfg_err), 32'(x.err));
      end
   end
   initial begin
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = '0;
      //  name        rst iv data      ordy   fl wr cm       ov     ir b  cnt mask   err
      v("reset",      0, 0, 16'h0000, 7'h00, 0, 0, 7'h00,  7'h00, 0, 0, 0, 7'h07, 0);
      v("idle",       1, 0, 16'h0000, 7'h00, 0, 0, 7'h00,  7'h00, 0, 0, 0, 7'h07, 0);
      v("one_cycle",  1, 1, 16'h00A5, 7'h7F, 0, 0, 7'h00,  7'h07, 1, 0, 0, 7'h07, 0);
      v("after_one",  1, 0, 16'h0000, 7'h00, 0, 0, 7'h00,  7'h00, 0, 0, 1, 7'h07, 0);
      v("stag_c1",    1, 1, 16'h1234, 7'h01, 0, 0, 7'h00,  7'h07, 0, 0, 1, 7'h07, 0);
      v("stag_c2",    1, 1, 16'h1234, 7'h02, 0, 0, 7'h00,  7'h06, 0, 1, 1, 7'h07, 0);
      v("stag_c3",    1, 1, 16'h1234, 7'h04, 0, 0, 7'h00,  7'h04, 1, 1, 1, 7'h07, 0);
      v("stag_done",  1, 0, 16'h0000, 7'h00, 0, 0, 7'h00,  7'h00, 0, 0, 2, 7'h07, 0);
      v("part_start", 1, 1, 16'hBEEF, 7'h01, 0, 0, 7'h00,  7'h07, 0, 0, 2, 7'h07, 0);
      v("cfg_busy",   1, 1, 16'hBEEF, 7'h00, 0, 1, 7'h7F,  7'h06, 0, 1, 2, 7'h07, 0);
      v("cfg_err",    1, 1, 16'hBEEF, 7'h00, 0, 0, 7'h00,  7'h06, 0, 1, 2, 7'h07, 1);
      v("take_b1",    1, 1, 16'hBEEF, 7'h02, 0, 0, 7'h00,  7'h06, 0, 1, 2, 7'h07, 0);
      v("flush",      1, 1, 16'hBEEF, 7'h00, 1, 0, 7'h00,  7'h04, 0, 1, 2, 7'h07, 0);
      v("post_flush", 1, 1, 16'hBEEF, 7'h00, 0, 0, 7'h00,  7'h07, 0, 0, 2, 7'h07, 0);
      v("flush_fire", 1, 1, 16'hC0DE, 7'h7F, 1, 0, 7'h00,  7'h07, 1, 0, 2, 7'h07, 0);
      v("ff_nocount", 1, 0, 16'h0000, 7'h00, 0, 0, 7'h00,  7'h00, 0, 0, 2, 7'h07, 0);
      v("cfg_ok",     1, 0, 16'h0000, 7'h00, 0, 1, 7'h7F,  7'h00, 0, 0, 2, 7'h07, 0);
      v("cfg_ok_chk", 1, 0, 16'h0000, 7'h00, 0, 0, 7'h00,  7'h00, 0, 0, 2, 7'h7F, 0);
      v("cfg_acc",    1, 1, 16'h5555, 7'h01, 0, 1, 7'h00,  7'h7F, 0, 0, 2, 7'h7F, 0);
      v("cfg_acc_e",  1, 1, 16'h5555, 7'h7E, 0, 0, 7'h00,  7'h7E, 1, 1, 2, 7'h7F, 1);
      v("cfg_zero",   1, 0, 16'h0000, 7'h00, 0, 1, 7'h00,  7'h00, 0, 0, 3, 7'h7F, 0);
      for (int i = 0; i < 5; i++)
         v("sink",    1, 1, 16'(16'h0100 + i), 7'h00, 0, 0, 7'h00, 7'h00, 1, 0, 4'(3 + i), 7'h00, 0);
      v("sink_done",  1, 0, 16'h0000, 7'h00, 0, 0, 7'h00,  7'h00, 1, 0, 8, 7'h00, 0);
      v("cfg_back",   1, 0, 16'h0000, 7'h00, 0, 1, 7'h07,  7'h00, 1, 0, 8, 7'h00, 0);
      for (int i = 0; i < 9; i++)
         v("wrap",    1, 1, 16'(16'h0200 + i), 7'h07, 0, 0, 7'h00, 7'h07, 1, 0, 4'(8 + i), 7'h07, 0);
      v("wrap_part",  1, 1, 16'hAAAA, 7'h01, 0, 0, 7'h00,  7'h07, 0, 0, 1, 7'h07, 0);
      v("async_rst",  0, 0, 16'h0000, 7'h00, 0, 0, 7'h00,  7'h00, 0, 0, 0, 7'h07, 0);
      v("rst_lost",   1, 1, 16'hAAAA, 7'h00, 0, 0, 7'h00,  7'h07, 0, 0, 0, 7'h07, 0);
      v("final",      1, 0, 16'h0000, 7'h00, 0, 0, 7'h00,  7'h00, 0, 0, 0, 7'h07, 0);
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending %0d want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fanout_fork_ctrl.md
Name: fanout_fork_ctrl

Overview:
- Sequential eager-fork controller for one interconnect fanout point: a single ready/valid producer broadcasts to NUM_BRANCH consumers.
- Consumers may accept the same token in different cycles. Per-branch "taken" state is tracked so the upstream ready is released only once every enabled branch has accepted.
- Replaces the purely combinational ready-AND fanout where consumers stall independently. Sits between a switch-box output mux and its fanout tracks, and is configured through the tile config bus.

Parameters:
- NUM_BRANCH, 7: number of fanout branches.
- DATA_WIDTH, 16: payload width.
- RESET_MASK, 0: branch-enable mask value loaded at reset.
- CNT_WIDTH, 16: width of the completed-token counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of in-flight branch state
- cfg_wr  in  1  config write strobe
- cfg_mask  in  NUM_BRANCH  branch-enable mask write data
- cfg_err  out  1  one-cycle pulse when a config write is rejected
- mask_q  out  NUM_BRANCH  current branch-enable mask
- in_valid  in  1  upstream valid
- in_data  in  DATA_WIDTH  upstream payload
- in_ready  out  1  upstream ready
- out_valid  out  NUM_BRANCH  per-branch valid
- out_data  out  DATA_WIDTH  shared payload, equal to in_data
- out_ready  in  NUM_BRANCH  per-branch ready
- busy  out  1  a token is partially delivered
- tok_count  out  CNT_WIDTH  completed tokens, wraps

Behaviour:
- Reset: taken = 0, mask_q = RESET_MASK, state = IDLE, tok_count = 0, cfg_err = 0, busy = 0.
  - Outputs follow combinationally from these values; no pulse is emitted on reset release.
- Combinational, zero-latency path:
  - out_valid[i] = in_valid & mask_q[i] & ~taken[i].
  - acc[i] = out_valid[i] & out_ready[i].
  - in_ready = AND over i of (~mask_q[i] | taken[i] | out_ready[i]).
  - out_data = in_data.
- fire = in_valid & in_ready.
- State machine, two states:
  - IDLE (taken == 0). On fire: stay IDLE, tok_count += 1. Else if any acc: taken <= acc, go to PARTIAL.
  - PARTIAL (taken != 0). On fire: taken <= 0, tok_count += 1, go to IDLE. Else: taken <= taken | acc.
  - busy = (state == PARTIAL).
- A branch never sees the same token twice: out_valid[i] stays low from the cycle after its acceptance until the token completes.
- All-disabled mask (mask_q == 0):
  - in_ready = 1 and out_valid = 0. Every valid token is consumed and counted (sink mode).
- Config writes:
  - Accepted in IDLE with no acc in the same cycle: mask_q <= cfg_mask at the next edge.
  - Otherwise rejected: mask_q is unchanged and cfg_err is high for the following cycle only.
  - The new mask affects handshakes starting the cycle after the write.
- Flush:
  - Highest priority. taken <= 0, state <= IDLE, cfg write ignored without error, tok_count unchanged.
  - A fire in the same cycle is not counted.
  - in_ready/out_valid are still driven combinationally that cycle, so upstream may observe a handshake. Flush is only used with upstream quiesced.
- in_valid dropping while PARTIAL is a protocol violation. taken is held and no reset occurs; the next valid token completes against the held taken bits.
- tok_count wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Async reset mid-token: all state is cleared immediately and the partial token is lost.

Decomposition:
- Shared package fanout_pkg holds:
  - the state enum (FORK_IDLE, FORK_PARTIAL),
  - default NUM_BRANCH/DATA_WIDTH constants,
  - a typedef for the branch mask vector.
- One sub-module, fanout_ready_and: the pure combinational in_ready reduction over (mask, taken, out_ready). It is reused by the existing combinational fanout path.
- Everything else lives in fanout_fork_ctrl.

Test Plan:
- Mask 7'b0000111, in_valid=1 holding 0x00A5, out_ready[2:0] all 1 in one cycle:
  - in_ready=1 that cycle, tok_count 0->1, busy stays 0.
- Mask 7'b0000111, cycle 1 out_ready=3'b001, cycle 2 3'b010, cycle 3 3'b100:
  - out_valid = 001-masked 111, then 110, then 100.
  - in_ready high only in cycle 3; busy high in cycles 2-3.
  - Each branch sees exactly one handshake; tok_count=1.
- Mask 0, in_valid=1 for 5 cycles:
  - out_valid=0, in_ready=1, tok_count=5.
- While PARTIAL, taken=3'b001, cfg_wr with mask 7'h7F:
  - cfg_err pulses 1 cycle and mask_q is unchanged.
  - Repeat in IDLE: mask_q=7'h7F, no error.
- PARTIAL with taken=3'b011, assert flush:
  - Next cycle taken=0 and busy=0; out_valid returns to 3'b111 with in_valid held; tok_count unchanged.
- CNT_WIDTH=4, complete 17 tokens -> tok_count=1.
  - Assert rst_n=0 asynchronously while PARTIAL -> all outputs at reset values before the next clk edge.
